// File: rtl/ay38500_pkg.sv
// Shared types and defaults for the paddle ramp generator.
package ay38500_pkg;

    // Where a player's paddle value comes from each frame.
    typedef enum logic [1:0] {
        DIGITAL = 2'd0,
        AXIS_Y  = 2'd1,
        AXIS_X  = 2'd2,
        PADDLE  = 2'd3
    } ctrl_mode_e;

    localparam int DEF_POS_INIT  = 128;
    localparam int DEF_STEP_SLOW = 5;
    localparam int DEF_STEP_FAST = 8;

    // Two's-complement stick axis -> unsigned 0..255 with centre at 128.
    function automatic logic [7:0] offset_binary(input logic [7:0] s);
        return {~s[7], s[6:0]};
    endfunction

endpackage

// File: rtl/paddle_channel.sv
// One player's paddle path: source select, digital position integrator
// and the per-line ramp counter whose expiry drives the chip's paddle pin.
module paddle_channel
    import ay38500_pkg::*;
#(
    parameter int POS_INIT  = DEF_POS_INIT,
    parameter int STEP_SLOW = DEF_STEP_SLOW,
    parameter int STEP_FAST = DEF_STEP_FAST
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        vs_rise,
    input  logic        hs_rise,
    input  logic [1:0]  mode,
    input  logic        invert,
    input  logic        speed,
    input  logic        up,
    input  logic        down,
    input  logic [15:0] analog,
    input  logic [7:0]  paddle,
    output logic [7:0]  pos,
    output logic        expired
);

    localparam logic [8:0] STEP_S = 9'(STEP_SLOW);
    localparam logic [8:0] STEP_F = 9'(STEP_FAST);
    localparam logic [7:0] POS_RST = 8'(POS_INIT);

    logic [8:0] cap_reg;
    logic [7:0] pos_reg;
    logic [7:0] pos_next;
    logic [7:0] src;
    logic [8:0] step;
    logic [8:0] sum;
    logic [8:0] diff;
    ctrl_mode_e mode_e;

    assign mode_e = ctrl_mode_e'(mode);

    // Select the frame's raw value; digital mode reports the pre-update position.
    always_comb begin
        src = pos_reg;
        case (mode_e)
            DIGITAL: src = pos_reg;
            AXIS_Y:  src = offset_binary(analog[15:8]);
            AXIS_X:  src = offset_binary(analog[7:0]);
            PADDLE:  src = paddle;
            default: src = pos_reg;
        endcase
    end

    // Clamped 9-bit step of the digital position; down wins over up.
    always_comb begin
        step     = speed ? STEP_F : STEP_S;
        sum      = {1'b0, pos_reg} + step;
        diff     = {1'b0, pos_reg} - step;
        pos_next = pos_reg;
        if (down) begin
            pos_next = sum[8] ? 8'hFF : sum[7:0];
        end else if (up) begin
            pos_next = diff[8] ? 8'h00 : diff[7:0];
        end
    end

    // Reload the ramp on vsync, count it down on each later hsync.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pos_reg <= POS_RST;
            cap_reg <= 9'd0;
        end else if (vs_rise) begin
            cap_reg <= {1'b0, src ^ {8{invert}}};
            if (mode_e == DIGITAL) begin
                pos_reg <= pos_next;
            end
        end else if (hs_rise && (cap_reg != 9'd0)) begin
            cap_reg <= cap_reg - 9'd1;
        end
    end

    assign pos     = pos_reg;
    assign expired = (cap_reg == 9'd0);

endmodule

// File: rtl/paddle_ramp_gen.sv
// Paddle ramp generator: sync edge detection shared by both players,
// two paddle channels, and practice-mode mirroring of the right input.
module paddle_ramp_gen
    import ay38500_pkg::*;
#(
    parameter int POS_INIT  = DEF_POS_INIT,
    parameter int STEP_SLOW = DEF_STEP_SLOW,
    parameter int STEP_FAST = DEF_STEP_FAST
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic [1:0]  mode_p1,
    input  logic [1:0]  mode_p2,
    input  logic        invert_p1,
    input  logic        invert_p2,
    input  logic        speed,
    input  logic [1:0]  up,
    input  logic [1:0]  down,
    input  logic [15:0] analog_0,
    input  logic [15:0] analog_1,
    input  logic [7:0]  paddle_0,
    input  logic [7:0]  paddle_1,
    input  logic        practice,
    output logic        lp_in,
    output logic        rp_in,
    output logic [7:0]  pos_p1,
    output logic [7:0]  pos_p2
);

    logic hs_d_reg;
    logic vs_d_reg;
    logic hs_rise;
    logic vs_rise;

    logic [1:0][1:0]  mode_v;
    logic [1:0]       invert_v;
    logic [1:0][15:0] analog_v;
    logic [1:0][7:0]  paddle_v;
    logic [1:0][7:0]  pos_v;
    logic [1:0]       expired_v;

    // One-cycle history of the sync inputs for rising-edge detection.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_d_reg <= 1'b0;
            vs_d_reg <= 1'b0;
        end else begin
            hs_d_reg <= hs;
            vs_d_reg <= vs;
        end
    end

    assign vs_rise = vs & ~vs_d_reg;
    // A coincident vsync reload takes priority over the line decrement.
    assign hs_rise = hs & ~hs_d_reg & ~vs_rise;

    assign mode_v   = {mode_p2, mode_p1};
    assign invert_v = {invert_p2, invert_p1};
    assign analog_v = {analog_1, analog_0};
    assign paddle_v = {paddle_1, paddle_0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            paddle_channel #(
                .POS_INIT  (POS_INIT),
                .STEP_SLOW (STEP_SLOW),
                .STEP_FAST (STEP_FAST)
            ) u_chan (
                .clk_sys (clk_sys),
                .reset   (reset),
                .vs_rise (vs_rise),
                .hs_rise (hs_rise),
                .mode    (mode_v[gi]),
                .invert  (invert_v[gi]),
                .speed   (speed),
                .up      (up[gi]),
                .down    (down[gi]),
                .analog  (analog_v[gi]),
                .paddle  (paddle_v[gi]),
                .pos     (pos_v[gi]),
                .expired (expired_v[gi])
            );
        end
    endgenerate

    assign pos_p1 = pos_v[0];
    assign pos_p2 = pos_v[1];
    assign lp_in  = expired_v[0];
    assign rp_in  = practice ? expired_v[0] : expired_v[1];

endmodule

// File: tb/tb_paddle_ramp_gen.sv
// Self-checking bench for paddle_ramp_gen: a frame/line level model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_paddle_ramp_gen;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        hs = 1'b0, vs = 1'b0;
    logic [1:0]  mode_p1 = 2'd0, mode_p2 = 2'd0;
    logic        invert_p1 = 1'b0, invert_p2 = 1'b0;
    logic        speed = 1'b0;
    logic [1:0]  up = 2'b00, down = 2'b00;
    logic [15:0] analog_0 = 16'h0000, analog_1 = 16'h0000;
    logic [7:0]  paddle_0 = 8'd0, paddle_1 = 8'd0;
    logic        practice = 1'b0;
    logic        lp_in, rp_in;
    logic [7:0]  pos_p1, pos_p2;

    int n_cmp = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    paddle_ramp_gen dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .hs        (hs),
        .vs        (vs),
        .mode_p1   (mode_p1),
        .mode_p2   (mode_p2),
        .invert_p1 (invert_p1),
        .invert_p2 (invert_p2),
        .speed     (speed),
        .up        (up),
        .down      (down),
        .analog_0  (analog_0),
        .analog_1  (analog_1),
        .paddle_0  (paddle_0),
        .paddle_1  (paddle_1),
        .practice  (practice),
        .lp_in     (lp_in),
        .rp_in     (rp_in),
        .pos_p1    (pos_p1),
        .pos_p2    (pos_p2)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- behavioural model ----------------
    int m_pos [2] = '{128, 128};
    int m_cap [2] = '{0, 0};
    bit m_hs_prev = 0, m_vs_prev = 0;

    function automatic int frame_value(int ch);
        int v;
        int md;
        md = (ch == 0) ? int'(mode_p1) : int'(mode_p2);
        case (md)
            0: v = m_pos[ch];
            1: v = 128 + int'($signed((ch == 0) ? analog_0[15:8] : analog_1[15:8]));
            2: v = 128 + int'($signed((ch == 0) ? analog_0[7:0] : analog_1[7:0]));
            default: v = (ch == 0) ? int'(paddle_0) : int'(paddle_1);
        endcase
        if ((ch == 0) ? invert_p1 : invert_p2) v = 255 - v;
        return v;
    endfunction

    always @(posedge clk_sys) begin
        bit vs_edge, hs_edge;
        int delta, md;
        if (reset) begin
            m_pos[0] = 128; m_pos[1] = 128;
            m_cap[0] = 0;   m_cap[1] = 0;
            m_hs_prev = 0;  m_vs_prev = 0;
        end else begin
            vs_edge = vs && !m_vs_prev;
            hs_edge = hs && !m_hs_prev;
            for (int ch = 0; ch < 2; ch++) begin
                if (vs_edge) begin
                    m_cap[ch] = frame_value(ch);
                    md = (ch == 0) ? int'(mode_p1) : int'(mode_p2);
                    if (md == 0) begin
                        delta = 0;
                        if (down[ch])    delta = speed ? 8 : 5;
                        else if (up[ch]) delta = speed ? -8 : -5;
                        m_pos[ch] = m_pos[ch] + delta;
                        if (m_pos[ch] < 0)   m_pos[ch] = 0;
                        if (m_pos[ch] > 255) m_pos[ch] = 255;
                    end
                end else if (hs_edge && m_cap[ch] > 0) begin
                    m_cap[ch] = m_cap[ch] - 1;
                end
            end
            m_hs_prev = hs;
            m_vs_prev = vs;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk_sys) begin
        bit exp_lp, exp_rp;
        if (check_en) begin
            exp_lp = (m_cap[0] == 0);
            exp_rp = practice ? exp_lp : (m_cap[1] == 0);
            n_cmp++;
            if (lp_in !== exp_lp || rp_in !== exp_rp ||
                pos_p1 !== 8'(m_pos[0]) || pos_p2 !== 8'(m_pos[1])) begin
                n_fail++;
                $display("FAIL model t=%0t: lp=%b rp=%b p1=%0d p2=%0d required lp=%b rp=%b p1=%0d p2=%0d",
                         $time, lp_in, rp_in, pos_p1, pos_p2, exp_lp, exp_rp, m_pos[0], m_pos[1]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
    endtask

    task automatic frame();
        vs = 1'b1; tick();
        vs = 1'b0; tick();
    endtask

    task automatic lines(input int n);
        repeat (n) begin
            hs = 1'b1; tick();
            hs = 1'b0; tick();
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end else begin
            $display("check %s: %0d ok", name, act);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(3);
        reset = 1'b0; tick();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        tick(3);
        check_en = 1'b1;
        chk("reset_lp", int'(lp_in), 1);
        chk("reset_rp", int'(rp_in), 1);
        chk("reset_pos1", int'(pos_p1), 128);
        reset = 1'b0; tick();

        // Digital, idle buttons: ramp of 128 lines.
        frame();
        chk("dig_lp_after_vs", int'(lp_in), 0);
        lines(127);
        chk("dig_lp_127", int'(lp_in), 0);
        lines(1);
        chk("dig_lp_128", int'(lp_in), 1);

        // Up held at slow speed: 128 - 5k, clamped at 0.
        do_reset();
        up = 2'b01;
        for (int k = 1; k <= 30; k++) begin
            frame();
            if (k == 1)  chk("up_f1", int'(pos_p1), 123);
            if (k == 25) chk("up_f25", int'(pos_p1), 3);
            if (k == 26) chk("up_f26", int'(pos_p1), 0);
        end
        chk("up_f30", int'(pos_p1), 0);
        chk("p2_idle", int'(pos_p2), 128);

        // Down from 0 at slow speed to 250, then fast -> clamp at 255.
        up = 2'b00; down = 2'b01;
        repeat (50) frame();
        chk("down_250", int'(pos_p1), 250);
        speed = 1'b1;
        frame();
        chk("down_fast_255", int'(pos_p1), 255);

        // Both buttons on P2: down wins, 128 + 8.
        speed = 1'b1; down = 2'b10; up = 2'b10;
        frame();
        chk("both_down_wins", int'(pos_p2), 136);
        down = 2'b00; up = 2'b00; speed = 1'b0;

        // Analog Y at -128: cap 0; inverted: cap 255, expiring on line 255.
        mode_p1 = 2'd1; analog_0 = 16'h8000;
        frame();
        chk("axis_y_min_lp", int'(lp_in), 1);
        lines(5);
        chk("axis_y_min_lp_hold", int'(lp_in), 1);
        invert_p1 = 1'b1;
        frame();
        chk("axis_y_inv_lp", int'(lp_in), 0);
        lines(254);
        chk("cap255_line254", int'(lp_in), 0);
        lines(1);
        chk("cap255_line255", int'(lp_in), 1);
        chk("pos_held_analog", int'(pos_p1), 255);

        // Analog X on P2 (0x10 -> 144); invert flip mid-frame has no effect.
        mode_p2 = 2'd2; analog_1 = 16'h0010; invert_p1 = 1'b0;
        frame();
        invert_p2 = 1'b1;
        lines(143);
        chk("axis_x_143", int'(rp_in), 0);
        lines(1);
        chk("axis_x_144", int'(rp_in), 1);
        invert_p2 = 1'b0;

        // Paddle mode: P1 = 10, P2 = 40; practice mirrors left.
        mode_p1 = 2'd3; mode_p2 = 2'd3; paddle_0 = 8'd10; paddle_1 = 8'd40;
        frame();
        lines(39);
        chk("paddle_rp_39", int'(rp_in), 0);
        lines(1);
        chk("paddle_rp_40", int'(rp_in), 1);
        practice = 1'b1;
        frame();
        chk("practice_rp_start", int'(rp_in), 0);
        lines(10);
        chk("practice_rp_10", int'(rp_in), 1);
        practice = 1'b0; tick();
        chk("practice_off_rp", int'(rp_in), 0);

        // Coincident hs/vs: reload to 20, no decrement.
        frame();
        paddle_0 = 8'd20;
        hs = 1'b1; vs = 1'b1; tick();
        hs = 1'b0; vs = 1'b0; tick();
        lines(19);
        chk("coincide_19", int'(lp_in), 0);
        lines(1);
        chk("coincide_20", int'(lp_in), 1);

        // Reset mid-ramp aborts on the next edge.
        paddle_0 = 8'd50;
        frame();
        lines(3);
        chk("pre_reset_lp", int'(lp_in), 0);
        reset = 1'b1; tick();
        chk("reset_abort_lp", int'(lp_in), 1);
        chk("reset_abort_rp", int'(rp_in), 1);
        reset = 1'b0; tick(2);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_ramp_gen.md
PADDLE_RAMP_GEN -- requirements
Module: paddle_ramp_gen

Interface
REQ-001 Parameter POS_INIT, default 128, is the digital-mode paddle position after reset.
REQ-002 Parameter STEP_SLOW, default 5, is the per-frame digital step when speed=0.
REQ-003 Parameter STEP_FAST, default 8, is the per-frame digital step when speed=1.
REQ-004 clk_sys  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 hs, vs  in  1 each  active-high horizontal and vertical sync from the game chip (inverted syncH/syncV).
REQ-007 mode_p1, mode_p2  in  2 each  control source: 0 digital, 1 analog Y, 2 analog X, 3 paddle.
REQ-008 invert_p1, invert_p2  in  1 each  invert the captured 8-bit value.
REQ-009 speed  in  1  selects STEP_FAST when 1.
REQ-010 up, down  in  2 each  bit0 = P1, bit1 = P2; keyboard OR joystick, level-sensitive.
REQ-011 analog_0, analog_1  in  16 each  signed stick axes: [15:8] Y, [7:0] X.
REQ-012 paddle_0, paddle_1  in  8 each  unsigned paddle positions.
REQ-013 practice  in  1  practice game selected; right input mirrors left.
REQ-014 lp_in, rp_in  out  1 each  active-high "ramp expired" inputs to the chip's pinLPin/pinRPin.
REQ-015 pos_p1, pos_p2  out  8 each  current digital positions (debug/OSD).

Function
REQ-016 The block SHALL register hs and vs once and detect rising edges as (x & ~x_d).
REQ-017 On a vs rising edge, each channel SHALL load cap (9 bits) from its selected source, XORed with {8{invert}} in bits [7:0], bit 8 = 0.
REQ-018 Source values: digital = pos; Y = {~a[15], a[14:8]}; X = {~a[7], a[6:0]}; paddle = paddle_n.
REQ-019 On a vs rising edge in digital mode, pos SHALL update after capture (captured value is the pre-update pos).
REQ-020 Update rule: up gives max(pos-step, 0); down gives min(pos+step, 255); arithmetic in 9 bits, clamp on underflow/overflow.
REQ-021 With up and down both asserted, down SHALL take precedence.
REQ-022 In non-digital modes pos SHALL hold its value.
REQ-023 On an hs rising edge that is not also a vs rising edge, each nonzero cap SHALL decrement by 1; zero caps SHALL hold.
REQ-024 If vs and hs rise in the same cycle, vs SHALL win and no decrement occurs.
REQ-025 lp_in SHALL equal (cap_p1 == 0), decoded combinationally from the register with zero added latency.
REQ-026 rp_in SHALL equal practice ? lp_in : (cap_p2 == 0).
REQ-027 A mode, invert or speed change mid-frame SHALL take effect only at the next vs rising edge.
REQ-028 A cap of 255 SHALL reach 0 after exactly 255 hs rising edges.

Reset
REQ-029 While reset=1: pos_p1 = pos_p2 = POS_INIT, cap_p1 = cap_p2 = 0, and sync history registers = 0; therefore lp_in = rp_in = 1.
REQ-030 Reset asserted mid-ramp SHALL abort the ramp on the next clock edge.
REQ-031 The first vs edge after reset is detected only once vs_d = 0 has been observed.

Structure
REQ-032 Package ay38500_pkg SHALL hold ctrl_mode_e (DIGITAL, AXIS_Y, AXIS_X, PADDLE) and the default step/init constants.
REQ-033 Sub-module paddle_channel (source mux, pos integrator, cap counter) SHALL be instantiated twice.
REQ-034 The top level owns the edge detection and the practice mirroring only.

Verification
REQ-035 Reset, then digital mode, no buttons, one vs edge -> cap_p1 = 128; lp_in = 0; lp_in = 1 after the 128th hs edge.
REQ-036 Digital, speed=0, up held for 30 frames from pos 128 -> pos sequence 123, 118, …, clamps at 0 (frame 26 onward); down held with speed=1 from 250 -> 255.
REQ-037 mode=1, analog_0[15:8] = 8'h80 (-128), invert=0 -> cap = 0, lp_in stays 1; with invert=1 -> cap = 255.
REQ-038 mode=3, paddle_1 = 40, practice=0 -> rp_in rises after 40 hs edges; practice=1 -> rp_in tracks lp_in exactly.
REQ-039 hs and vs rise in the same cycle with cap=10 -> cap reloads, no decrement; reset asserted at cap=50 -> cap = 0 and lp_in = 1 next cycle.
